// File: rtl/game_sprite_motion_unit_if.sv
// rtl/game_sprite_motion_unit_if.sv - sprite control/status bus between game master and motion unit
//
// Purpose : bundles the game master's sprite control strobes and load values
//           together with the position/visibility status returned to it.
// Modports: master - drives strobes/load values, observes position/status
//           slave  - motion unit side
// Signals : sprite_write_xy, sprite_write_dxy, sprite_write_x/y/dx/dy,
//           sprite_enable_update, sprite_x, sprite_y, sprite_within_screen
interface game_sprite_motion_unit_if #(
  parameter int X_WIDTH   = 11,
  parameter int Y_WIDTH   = 11,
  parameter int DXY_WIDTH = 4
);
  logic                 sprite_write_xy;
  logic                 sprite_write_dxy;
  logic [X_WIDTH-1:0]   sprite_write_x;
  logic [Y_WIDTH-1:0]   sprite_write_y;
  logic [DXY_WIDTH-1:0] sprite_write_dx;
  logic [DXY_WIDTH-1:0] sprite_write_dy;
  logic                 sprite_enable_update;
  logic [X_WIDTH-1:0]   sprite_x;
  logic [Y_WIDTH-1:0]   sprite_y;
  logic                 sprite_within_screen;

  modport master (
    output sprite_write_xy, sprite_write_dxy,
    output sprite_write_x, sprite_write_y, sprite_write_dx, sprite_write_dy,
    output sprite_enable_update,
    input  sprite_x, sprite_y, sprite_within_screen
  );

  modport slave (
    input  sprite_write_xy, sprite_write_dxy,
    input  sprite_write_x, sprite_write_y, sprite_write_dx, sprite_write_dy,
    input  sprite_enable_update,
    output sprite_x, sprite_y, sprite_within_screen
  );
endinterface

// File: rtl/game_sprite_motion_unit.sv
// rtl/game_sprite_motion_unit.sv - per-sprite position/velocity engine with screen test and pixel hit
//
// Purpose : holds a sprite's signed position and velocity, steps the position
//           once every UPDATE_PERIOD enabled clocks, reports whether the sprite
//           box overlaps the screen and produces a registered pixel hit/colour.
// Ports   : clk, rst (synchronous, active-high)
//           bus     - game_sprite_motion_unit_if.slave (strobes, loads, status)
//           pixel_x, pixel_y - current display pixel
//           rgb_en, rgb      - registered hit flag and colour (1-cycle latency)
// Option  : GAME_SPRITE_WRAP_EN - a step leaving the screen re-enters on the
//           opposite side and keeps sprite_within_screen at 1.
module game_sprite_motion_unit #(
  parameter int         SCREEN_WIDTH  = 640,
  parameter int         SCREEN_HEIGHT = 480,
  parameter int         X_WIDTH       = 11,
  parameter int         Y_WIDTH       = 11,
  parameter int         DXY_WIDTH     = 4,
  parameter int         SPRITE_WIDTH  = 8,
  parameter int         SPRITE_HEIGHT = 8,
  parameter int         UPDATE_PERIOD = 1000000,
  parameter logic [2:0] SPRITE_RGB    = 3'b110
) (
  input  logic                      clk,
  input  logic                      rst,
  game_sprite_motion_unit_if.slave  bus,
  input  logic [9:0]                pixel_x,
  input  logic [9:0]                pixel_y,
  output logic                      rgb_en,
  output logic [2:0]                rgb
);

  localparam int CNT_W = $clog2(UPDATE_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UPDATE_PERIOD - 1);

  // Compare widths: wide enough for the 10-bit pixel coordinates plus sign and
  // sprite extent, so no comparison can overflow.
  localparam int XC = ((X_WIDTH > 10) ? X_WIDTH : 10) + 2;
  localparam int YC = ((Y_WIDTH > 10) ? Y_WIDTH : 10) + 2;
  typedef logic signed [XC-1:0] xc_t;
  typedef logic signed [YC-1:0] yc_t;

  localparam xc_t SW_C   = xc_t'(SCREEN_WIDTH);
  localparam xc_t SPW_C  = xc_t'(SPRITE_WIDTH);
  localparam yc_t SH_C   = yc_t'(SCREEN_HEIGHT);
  localparam yc_t SPH_C  = yc_t'(SPRITE_HEIGHT);
  localparam xc_t ZERO_X = '0;
  localparam yc_t ZERO_Y = '0;
`ifdef GAME_SPRITE_WRAP_EN
  localparam xc_t WRAP_X     = xc_t'(SCREEN_WIDTH + SPRITE_WIDTH);
  localparam yc_t WRAP_Y     = yc_t'(SCREEN_HEIGHT + SPRITE_HEIGHT);
  localparam xc_t NEG_SPW_C  = xc_t'(-SPRITE_WIDTH);
  localparam yc_t NEG_SPH_C  = yc_t'(-SPRITE_HEIGHT);
`endif

  logic [X_WIDTH-1:0]   x_q, x_d;
  logic [Y_WIDTH-1:0]   y_q, y_d;
  logic [DXY_WIDTH-1:0] dx_q, dx_d;
  logic [DXY_WIDTH-1:0] dy_q, dy_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 within_q, within_d;
  logic                 rgb_en_q, rgb_en_d;
  logic [2:0]           rgb_q, rgb_d;

  logic step;
  xc_t  x_sum, xd_ext, x_ext, px_ext;
  yc_t  y_sum, yd_ext, y_ext, py_ext;
  logic in_screen;
  logic hit;

  always_comb begin
    step = bus.sprite_enable_update && (cnt_q == CNT_LAST);

    if (!bus.sprite_enable_update || step) cnt_d = '0;
    else                                   cnt_d = cnt_q + 1'b1;

    x_sum = xc_t'($signed(x_q)) + xc_t'($signed(dx_q));
    y_sum = yc_t'($signed(y_q)) + yc_t'($signed(dy_q));
`ifdef GAME_SPRITE_WRAP_EN
    if (x_sum >= SW_C)           x_sum = x_sum - WRAP_X;
    else if (x_sum <= NEG_SPW_C) x_sum = x_sum + WRAP_X;
    if (y_sum >= SH_C)           y_sum = y_sum - WRAP_Y;
    else if (y_sum <= NEG_SPH_C) y_sum = y_sum + WRAP_Y;
`endif

    // A position load wins over a step; the step is simply lost.
    x_d = x_q;
    y_d = y_q;
    if (bus.sprite_write_xy) begin
      x_d = bus.sprite_write_x;
      y_d = bus.sprite_write_y;
    end else if (step) begin
      x_d = X_WIDTH'(x_sum);
      y_d = Y_WIDTH'(y_sum);
    end

    // The step above already consumed the old velocity.
    dx_d = bus.sprite_write_dxy ? bus.sprite_write_dx : dx_q;
    dy_d = bus.sprite_write_dxy ? bus.sprite_write_dy : dy_q;

    xd_ext    = xc_t'($signed(x_d));
    yd_ext    = yc_t'($signed(y_d));
    in_screen = ((xd_ext + SPW_C) > ZERO_X) && (xd_ext < SW_C) &&
                ((yd_ext + SPH_C) > ZERO_Y) && (yd_ext < SH_C);

    // Visibility only changes when the position does; otherwise it is held.
    within_d = within_q;
    if (bus.sprite_write_xy) begin
      within_d = in_screen;
    end else if (step) begin
`ifdef GAME_SPRITE_WRAP_EN
      within_d = 1'b1;
`else
      within_d = in_screen;
`endif
    end

    x_ext  = xc_t'($signed(x_q));
    y_ext  = yc_t'($signed(y_q));
    px_ext = xc_t'(pixel_x);
    py_ext = yc_t'(pixel_y);
    hit    = (px_ext >= x_ext) && (px_ext < (x_ext + SPW_C)) &&
             (py_ext >= y_ext) && (py_ext < (y_ext + SPH_C));

    rgb_en_d = hit;
    rgb_d    = hit ? SPRITE_RGB : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= '0;
      y_q      <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      cnt_q    <= '0;
      within_q <= 1'b1;
      rgb_en_q <= 1'b0;
      rgb_q    <= 3'b000;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      cnt_q    <= cnt_d;
      within_q <= within_d;
      rgb_en_q <= rgb_en_d;
      rgb_q    <= rgb_d;
    end
  end

  assign bus.sprite_x             = x_q;
  assign bus.sprite_y             = y_q;
  assign bus.sprite_within_screen = within_q;
  assign rgb_en                   = rgb_en_q;
  assign rgb                      = rgb_q;

endmodule

// File: tb/tb_game_sprite_motion_unit.sv
// tb/tb_game_sprite_motion_unit.sv - self-checking bench for game_sprite_motion_unit
module tb_game_sprite_motion_unit;
  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] pixel_x, pixel_y;
  logic       rgb_en;
  logic [2:0] rgb;

  always #5 clk = ~clk;

  game_sprite_motion_unit_if #(.X_WIDTH(11), .Y_WIDTH(11), .DXY_WIDTH(4)) bus ();

  game_sprite_motion_unit #(
    .SCREEN_WIDTH(640), .SCREEN_HEIGHT(480), .X_WIDTH(11), .Y_WIDTH(11),
    .DXY_WIDTH(4), .SPRITE_WIDTH(8), .SPRITE_HEIGHT(8),
    .UPDATE_PERIOD(P), .SPRITE_RGB(3'b110)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .rgb_en(rgb_en), .rgb(rgb)
  );

  int total = 0;
  int bad   = 0;

  // Reference state in plain integers.
  int mx, my, mdx, mdy, streak, mwin, mrgb_en;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int wrap11(input int v);
    int r;
    r = ((v % 2048) + 2048) % 2048;
    if (r >= 1024) r -= 2048;
    return r;
  endfunction

  function automatic int onscr(input int x, input int y);
    return ((x + 8 > 0) && (x < 640) && (y + 8 > 0) && (y < 480)) ? 1 : 0;
  endfunction

  function automatic int wrap_axis(input int v, input int scr);
`ifdef GAME_SPRITE_WRAP_EN
    if (v >= scr)     return v - (scr + 8);
    else if (v <= -8) return v + (scr + 8);
`endif
    return v;
  endfunction

  task automatic model_update();
    int px, py, hit, step;
    if (rst) begin
      mx = 0; my = 0; mdx = 0; mdy = 0; streak = 0; mwin = 1; mrgb_en = 0;
      return;
    end
    px = int'(pixel_x);
    py = int'(pixel_y);
    hit = (px >= mx && px < mx + 8 && py >= my && py < my + 8) ? 1 : 0;
    mrgb_en = hit;
    step = 0;
    if (!bus.sprite_enable_update) streak = 0;
    else begin
      streak++;
      if (streak % P == 0) step = 1;
    end
    if (bus.sprite_write_xy) begin
      mx = int'($signed(bus.sprite_write_x));
      my = int'($signed(bus.sprite_write_y));
      mwin = onscr(mx, my);
    end else if (step != 0) begin
      mx = wrap11(wrap_axis(mx + mdx, 640));
      my = wrap11(wrap_axis(my + mdy, 480));
`ifdef GAME_SPRITE_WRAP_EN
      mwin = 1;
`else
      mwin = onscr(mx, my);
`endif
    end
    if (bus.sprite_write_dxy) begin
      mdx = int'($signed(bus.sprite_write_dx));
      mdy = int'($signed(bus.sprite_write_dy));
    end
  endtask

  // One clock: model follows the edge, then every output is compared.
  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    chk("sprite_x", int'($signed(bus.sprite_x)), mx);
    chk("sprite_y", int'($signed(bus.sprite_y)), my);
    chk("within", int'(bus.sprite_within_screen), mwin);
    chk("rgb_en", int'(rgb_en), mrgb_en);
    chk("rgb", int'(rgb), (mrgb_en != 0) ? 6 : 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wr_xy(input int x, input int y);
    bus.sprite_write_xy = 1'b1;
    bus.sprite_write_x  = 11'(x);
    bus.sprite_write_y  = 11'(y);
    cycle();
    bus.sprite_write_xy = 1'b0;
  endtask

  task automatic wr_dxy(input int dx, input int dy);
    bus.sprite_write_dxy = 1'b1;
    bus.sprite_write_dx  = 4'(dx);
    bus.sprite_write_dy  = 4'(dy);
    cycle();
    bus.sprite_write_dxy = 1'b0;
  endtask

  function automatic int sx();
    return int'($signed(bus.sprite_x));
  endfunction

  function automatic int sy();
    return int'($signed(bus.sprite_y));
  endfunction

  initial begin
    rst = 1'b1;
    pixel_x = '0; pixel_y = '0;
    bus.sprite_write_xy = 1'b0; bus.sprite_write_dxy = 1'b0;
    bus.sprite_write_x = '0; bus.sprite_write_y = '0;
    bus.sprite_write_dx = '0; bus.sprite_write_dy = '0;
    bus.sprite_enable_update = 1'b0;
    mx = 0; my = 0; mdx = 0; mdy = 0; streak = 0; mwin = 1; mrgb_en = 0;

    run(2);
    rst = 1'b0;
    chk("lit_rst_x", sx(), 0);
    chk("lit_rst_within", int'(bus.sprite_within_screen), 1);
    chk("lit_rst_rgb_en", int'(rgb_en), 0);

    wr_xy(100, 200);
    chk("lit_load_x", sx(), 100);
    chk("lit_load_y", sy(), 200);

    // Velocity (+3,-2), eight enabled cycles.
    wr_dxy(3, -2);
    bus.sprite_enable_update = 1'b1;
    run(4);
    chk("lit_step1_x", sx(), 103);
    chk("lit_step1_y", sy(), 198);
    run(4);
    chk("lit_step2_x", sx(), 106);
    chk("lit_step2_y", sy(), 196);
    bus.sprite_enable_update = 1'b0;
    run(6);
    chk("lit_hold_x", sx(), 106);

    // Right screen edge.
    wr_xy(639, 0);
    chk("lit_639_within", int'(bus.sprite_within_screen), 1);
    wr_xy(640, 0);
    chk("lit_640_within", int'(bus.sprite_within_screen), 0);
    wr_xy(636, 0);
    wr_dxy(4, 0);
    bus.sprite_enable_update = 1'b1;
    run(3);
    chk("lit_636_within", int'(bus.sprite_within_screen), 1);
    run(1);
`ifdef GAME_SPRITE_WRAP_EN
    chk("lit_wrap_right_x", sx(), -8);
    chk("lit_wrap_right_within", int'(bus.sprite_within_screen), 1);
`else
    chk("lit_edge_right_x", sx(), 640);
    chk("lit_edge_right_within", int'(bus.sprite_within_screen), 0);
`endif
    bus.sprite_enable_update = 1'b0;

    // Left screen edge.
    wr_xy(-7, 0);
    chk("lit_m7_within", int'(bus.sprite_within_screen), 1);
    wr_dxy(-1, 0);
    bus.sprite_enable_update = 1'b1;
    run(4);
`ifdef GAME_SPRITE_WRAP_EN
    chk("lit_wrap_left_x", sx(), 640);
    chk("lit_wrap_left_within", int'(bus.sprite_within_screen), 1);
`else
    chk("lit_edge_left_x", sx(), -8);
    chk("lit_edge_left_within", int'(bus.sprite_within_screen), 0);
`endif
    bus.sprite_enable_update = 1'b0;

    // Same-cycle priority.
    wr_xy(100, 200);
    wr_dxy(3, 0);
    bus.sprite_enable_update = 1'b1;
    run(3);
    wr_xy(50, 60);
    chk("lit_xy_beats_step_x", sx(), 50);
    chk("lit_xy_beats_step_y", sy(), 60);
    run(4);
    chk("lit_after_load_step", sx(), 53);
    run(3);
    wr_dxy(5, 0);
    chk("lit_old_dx_used", sx(), 56);
    run(4);
    chk("lit_new_dx_used", sx(), 61);
    bus.sprite_enable_update = 1'b0;

    // Pixel sweep across the sprite row.
    wr_xy(100, 200);
    pixel_y = 10'd200;
    for (int px = 99; px <= 108; px++) begin
      pixel_x = 10'(px);
      cycle();
      chk("lit_sweep_rgb_en", int'(rgb_en), (px >= 100 && px <= 107) ? 1 : 0);
      chk("lit_sweep_rgb", int'(rgb), (px >= 100 && px <= 107) ? 6 : 0);
    end

    // Reset in the middle of a count restarts the period.
    bus.sprite_enable_update = 1'b1;
    run(2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    wr_dxy(2, 0);
    run(2);
    chk("lit_rst_mid_hold", sx(), 0);
    run(1);
    chk("lit_rst_mid_step", sx(), 2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      bus.sprite_write_xy = ($urandom_range(0, 39) == 0);
      bus.sprite_write_x  = 11'($urandom_range(0, 680) - 20);
      bus.sprite_write_y  = 11'($urandom_range(0, 520) - 20);
      bus.sprite_write_dxy = ($urandom_range(0, 19) == 0);
      bus.sprite_write_dx  = 4'($urandom);
      bus.sprite_write_dy  = 4'($urandom);
      if ($urandom_range(0, 19) == 0)
        bus.sprite_enable_update = ~bus.sprite_enable_update;
      if ($urandom_range(0, 1) == 0) begin
        pixel_x = 10'(mx + $urandom_range(0, 11) - 2);
        pixel_y = 10'(my + $urandom_range(0, 11) - 2);
      end else begin
        pixel_x = 10'($urandom);
        pixel_y = 10'($urandom);
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
